// File: rtl/psum_drain_unit_pkg.sv
// Shared state encoding and sizing helpers for the psum drain unit.
// Imported by the top level and its row-clamp sub-module.
package psum_drain_unit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // A single-row array still needs a one-bit counter.
    function automatic int rowCntBits(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    localparam int ROW_CNT_BITS = rowCntBits(16);

endpackage

// File: rtl/psum_drain_unit_if.sv
// Valid/ready beat channel from the drain unit to the psum global buffer.
interface psum_drain_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256
);
    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic [ADDR_W-1:0] o_addr;

    modport master (output o_valid, output o_data, output o_addr, input o_ready);
    modport slave  (input o_valid, input o_data, input o_addr, output o_ready);

endinterface

// File: rtl/psum_drain_unit_psum_row_relu.sv
// Combinational per-element signed clamp across one PE row (negative -> 0).
module psum_row_relu
    import psum_drain_unit_pkg::*;
#(
    parameter int COL          = 16,
    parameter int OUT_BITWIDTH = 16
)(
    input  logic [COL*OUT_BITWIDTH-1:0] i_row,
    input  logic                        i_en,
    output logic [COL*OUT_BITWIDTH-1:0] o_row
);

    always_comb begin
        o_row = i_row;
        for (int c = 0; c < COL; c++) begin
            if (i_en && i_row[c*OUT_BITWIDTH + OUT_BITWIDTH - 1]) begin
                o_row[c*OUT_BITWIDTH +: OUT_BITWIDTH] = '0;
            end
        end
    end

endmodule

// File: rtl/psum_drain_unit.sv
// Snapshots the PE array psums on a start pulse and streams them, one row per
// beat, to the psum global buffer so the array can keep accumulating meanwhile.
module psum_drain_unit
    import psum_drain_unit_pkg::*;
#(
    parameter int ROW               = 16,
    parameter int COL               = 16,
    parameter int OUT_BITWIDTH      = 16,
    parameter int GBF_ADDR_BITWIDTH = 8,
    parameter int GBF_DATA_BITWIDTH = 256
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic [OUT_BITWIDTH*ROW*COL-1:0]  psum_in,
    input  logic                             drain_start,
    input  logic                             drain_abort,
    input  logic                             relu_en,
    input  logic [GBF_ADDR_BITWIDTH-1:0]     base_addr,
    psum_drain_unit_if.master                gbf,
    output logic                             busy,
    output logic                             done
);

    localparam int ROW_W = GBF_DATA_BITWIDTH;
    localparam int CNT_W = rowCntBits(ROW);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROW - 1);

    logic [1:0]                   r_state;
    logic [CNT_W-1:0]             r_rowCnt;
    logic [GBF_ADDR_BITWIDTH-1:0] r_base;
    logic                         r_relu;
    logic [ROW_W-1:0]             r_snap [ROW];

    logic [ROW_W-1:0]             w_rows [ROW];
    logic [ROW_W-1:0]             w_reluRow;
    logic                         w_valid;

    // PE(0,0) is the most significant slice, so row r is one contiguous chunk
    // with PE(r,0) at its top: exactly the beat layout the GBF expects.
    always_comb begin
        for (int r = 0; r < ROW; r++) begin
            w_rows[r] = psum_in[(ROW-1-r)*ROW_W +: ROW_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rowCnt <= '0;
            r_base   <= '0;
            r_relu   <= 1'b0;
            for (int r = 0; r < ROW; r++) begin
                r_snap[r] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (drain_start) begin
                        r_snap   <= w_rows;
                        r_relu   <= relu_en;
                        r_base   <= base_addr;
                        r_rowCnt <= '0;
                        r_state  <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_abort) begin
                        r_state <= ST_IDLE;
                    end else if (gbf.o_ready) begin
                        if (r_rowCnt == LAST_ROW) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_rowCnt <= r_rowCnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    psum_row_relu #(
        .COL          (COL),
        .OUT_BITWIDTH (OUT_BITWIDTH)
    ) u_relu (
        .i_row (r_snap[r_rowCnt]),
        .i_en  (r_relu),
        .o_row (w_reluRow)
    );

    // Data and address are forced to zero outside DRAIN so a retained snapshot
    // after an abort never leaks onto the bus.
    assign w_valid     = (r_state == ST_DRAIN);
    assign gbf.o_valid = w_valid;
    assign gbf.o_data  = w_valid ? w_reluRow : '0;
    assign gbf.o_addr  = w_valid ? (r_base + GBF_ADDR_BITWIDTH'(r_rowCnt)) : '0;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_psum_drain_unit.sv
// Randomized bench for psum_drain_unit with a row/beat-level reference model.
module tb_psum_drain_unit;

    localparam int ROW   = 16;
    localparam int COL   = 16;
    localparam int W     = 16;
    localparam int AW    = 8;
    localparam int DW    = COL * W;
    localparam int TOTAL = W * ROW * COL;

    logic             clk = 1'b0;
    logic             reset;
    logic [TOTAL-1:0] psum_in;
    logic             drain_start;
    logic             drain_abort;
    logic             relu_en;
    logic [AW-1:0]    base_addr;
    logic             busy;
    logic             done;

    psum_drain_unit_if #(.ADDR_W(AW), .DATA_W(DW)) gbf ();

    psum_drain_unit #(
        .ROW               (ROW),
        .COL               (COL),
        .OUT_BITWIDTH      (W),
        .GBF_ADDR_BITWIDTH (AW),
        .GBF_DATA_BITWIDTH (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .psum_in     (psum_in),
        .drain_start (drain_start),
        .drain_abort (drain_abort),
        .relu_en     (relu_en),
        .base_addr   (base_addr),
        .gbf         (gbf),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: the psum matrix captured at start plus the latched options.
    logic [W-1:0]  mdl [ROW][COL];
    logic          mdlRelu;
    logic [AW-1:0] mdlBase;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] expData(input int r);
        logic [DW-1:0] d;
        logic [W-1:0]  v;
        d = '0;
        for (int c = 0; c < COL; c++) begin
            v = mdl[r][c];
            if (mdlRelu && v[W-1]) v = '0;
            d[(COL-1-c)*W +: W] = v;
        end
        return d;
    endfunction

    function automatic logic [AW-1:0] expAddr(input int r);
        return AW'((int'(mdlBase) + r) % (1 << AW));
    endfunction

    task automatic packModel();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                psum_in[(ROW*COL-1-(COL*r+c))*W +: W] = mdl[r][c];
    endtask

    task automatic randomPsumIn();
        for (int i = 0; i < TOTAL/32; i++) psum_in[i*32 +: 32] = $urandom;
    endtask

    // pattern 0: 16*r+c, 1: random, 2: random with PE(0,0)=-10, PE(0,1)=7.
    // readyMode 0: always ready, 1: random ready/start noise, 2: stall beats 3-5 for 4 cycles.
    task automatic applyStimulus(input int pattern, input logic [AW-1:0] base, input logic relu,
                                 input int readyMode, input int abortAfter, input int resetAt,
                                 input bit toggleIn, output int span);
        int beat;
        int stall;
        logic rdy;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mdl[r][c] = (pattern == 0) ? W'(16*r + c) : W'($urandom_range(0, 65535));
        if (pattern == 2) begin
            mdl[0][0] = 16'hFFF6;
            mdl[0][1] = 16'h0007;
        end
        packModel();
        mdlRelu = relu;
        mdlBase = base;
        drain_start = 1'b1;
        relu_en     = relu;
        base_addr   = base;
        drain_abort = (readyMode == 1);
        gbf.o_ready = 1'b0;
        tick();
        span = 1;
        drain_start = 1'b0;
        drain_abort = 1'b0;
        relu_en     = ~relu;
        base_addr   = AW'($urandom);
        beat  = 0;
        stall = 0;
        while (beat < ROW && span < 1000) begin
            if (toggleIn) randomPsumIn();
            if (readyMode == 1) drain_start = ($urandom_range(0, 3) == 0);
            case (readyMode)
                1: rdy = 1'($urandom_range(0, 1));
                2: begin
                    if (beat >= 3 && beat <= 5 && stall < 4) begin
                        rdy = 1'b0;
                        stall++;
                    end else rdy = 1'b1;
                end
                default: rdy = 1'b1;
            endcase
            gbf.o_ready = rdy;
            checkOutput("valid", DW'(gbf.o_valid), DW'(1));
            checkOutput($sformatf("data%0d", beat), gbf.o_data, expData(beat));
            checkOutput($sformatf("addr%0d", beat), DW'(gbf.o_addr), DW'(expAddr(beat)));
            checkOutput("busy_drain", DW'(busy), DW'(1));
            checkOutput("done_drain", DW'(done), DW'(0));
            if (beat == resetAt) begin
                drain_start = 1'b0;
                #3 reset = 1'b1;
                #1;
                checkOutput("rst_valid", DW'(gbf.o_valid), DW'(0));
                checkOutput("rst_busy", DW'(busy), DW'(0));
                checkOutput("rst_done", DW'(done), DW'(0));
                checkOutput("rst_addr", DW'(gbf.o_addr), DW'(0));
                checkOutput("rst_data", gbf.o_data, DW'(0));
                #2 reset = 1'b0;
                tick();
                checkOutput("rst_idle_busy", DW'(busy), DW'(0));
                return;
            end
            if (beat == abortAfter) begin
                drain_abort = 1'b1;
                tick();
                drain_abort = 1'b0;
                drain_start = 1'b0;
                checkOutput("abort_valid", DW'(gbf.o_valid), DW'(0));
                checkOutput("abort_busy", DW'(busy), DW'(0));
                checkOutput("abort_done", DW'(done), DW'(0));
                tick();
                checkOutput("abort_done2", DW'(done), DW'(0));
                return;
            end
            tick();
            span++;
            if (rdy) begin
                beat++;
                stall = 0;
            end
        end
        drain_start = 1'b0;
        if (beat < ROW) begin
            checkOutput("timeout", DW'(beat), DW'(ROW));
            return;
        end
        drain_abort = (readyMode == 1);
        checkOutput("done_pulse", DW'(done), DW'(1));
        checkOutput("done_busy", DW'(busy), DW'(1));
        checkOutput("done_valid", DW'(gbf.o_valid), DW'(0));
        tick();
        drain_abort = 1'b0;
        checkOutput("done_clear", DW'(done), DW'(0));
        checkOutput("idle_busy", DW'(busy), DW'(0));
        checkOutput("idle_valid", DW'(gbf.o_valid), DW'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int span;
        reset       = 1'b1;
        psum_in     = '0;
        drain_start = 1'b0;
        drain_abort = 1'b0;
        relu_en     = 1'b0;
        base_addr   = '0;
        gbf.o_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", DW'(gbf.o_valid), DW'(0));
        checkOutput("reset_busy", DW'(busy), DW'(0));
        checkOutput("reset_done", DW'(done), DW'(0));
        checkOutput("reset_addr", DW'(gbf.o_addr), DW'(0));
        checkOutput("reset_data", gbf.o_data, DW'(0));
        reset = 1'b0;
        tick();

        applyStimulus(0, 8'h10, 1'b0, 0, -1, -1, 1'b0, span);
        checkOutput("basic_span", DW'(span), DW'(ROW + 1));

        applyStimulus(2, AW'($urandom), 1'b1, 0, -1, -1, 1'b0, span);
        applyStimulus(2, AW'($urandom), 1'b0, 0, -1, -1, 1'b0, span);

        applyStimulus(0, 8'h10, 1'b0, 2, -1, -1, 1'b0, span);
        checkOutput("stall_span", DW'(span), DW'(ROW + 1 + 12));

        applyStimulus(1, 8'hFA, 1'($urandom), 0, -1, -1, 1'b1, span);

        applyStimulus(0, 8'h20, 1'b0, 0, 5, -1, 1'b0, span);
        applyStimulus(1, 8'h40, 1'b0, 0, -1, -1, 1'b0, span);
        checkOutput("restart_span", DW'(span), DW'(ROW + 1));

        for (int i = 0; i < 4; i++)
            applyStimulus(1, AW'($urandom), 1'($urandom), 1, -1, -1, 1'($urandom), span);

        applyStimulus(1, 8'h33, 1'b0, 0, -1, 7, 1'b0, span);
        applyStimulus(0, 8'h10, 1'b0, 0, -1, -1, 1'b0, span);
        checkOutput("post_reset_span", DW'(span), DW'(ROW + 1));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
